// File: rtl/cpu_pkg.sv
// Shared core definitions: ALU op codes, hazard FSM states, control bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int REG_AW = 5;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_MUL = 3'b111;

    typedef enum logic {
        RUN      = 1'b0,
        MUL_WAIT = 1'b1
    } hazard_state_t;

    // Pipeline control bundle driven by the hazard controller.
    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_bubble;
        logic branch_taken;
    } hz_ctl_t;

    localparam hz_ctl_t CTL_RUN  = '{pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1, default: 1'b0};
    localparam hz_ctl_t CTL_HOLD = '{exmem_bubble: 1'b1, default: 1'b0};

    function automatic logic is_mul(input logic [2:0] op);
        return op == ALU_MUL;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decoded ID/EX control inputs and pipeline enable/flush outputs of the hazard controller.
// Latency: n/a (wiring only).
// Backpressure: n/a; the enables themselves are the pipeline backpressure.
interface hazard_ctrl_if
    import cpu_pkg::*;
#(
    parameter int CNT_W = 32
);
    logic              mem_wait;
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_uses_rs2;
    logic              ex_valid;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_mem_read;
    logic [2:0]        ex_alu_op;
    logic              ex_branch;
    logic              ex_zero;

    logic              pc_en;
    logic              ifid_en;
    logic              idex_en;
    logic              ifid_flush;
    logic              idex_flush;
    logic              exmem_bubble;
    logic              branch_taken;
    logic              mul_busy;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output mem_wait, id_valid, id_rs1, id_rs2, id_uses_rs2,
               ex_valid, ex_rd, ex_mem_read, ex_alu_op, ex_branch, ex_zero,
        input  pc_en, ifid_en, idex_en, ifid_flush, idex_flush,
               exmem_bubble, branch_taken, mul_busy, stall_cnt
    );

    modport slave (
        input  mem_wait, id_valid, id_rs1, id_rs2, id_uses_rs2,
               ex_valid, ex_rd, ex_mem_read, ex_alu_op, ex_branch, ex_zero,
        output pc_en, ifid_en, idex_en, ifid_flush, idex_flush,
               exmem_bubble, branch_taken, mul_busy, stall_cnt
    );
endinterface

// File: rtl/load_use_det.sv
// Load-use detector: LW in EX writing a register the ID instruction reads.
// Latency: combinational.
// Backpressure: none; x0 destinations never flag a hazard.
module load_use_det
    import cpu_pkg::*;
(
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_uses_rs2,
    output logic              hazard
);
    assign hazard = ex_valid && ex_mem_read && (ex_rd != '0) && id_valid &&
                    ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use, taken BEQ, multi-cycle MUL, memory freeze.
// Latency: control outputs combinational; mul_busy and stall_cnt registered.
// Backpressure: mem_wait freezes everything including FSM; MUL holds PC/IF/ID/ID/EX for MUL_LAT-1 cycles.
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_ctrl_if.slave hz
);
    localparam logic [3:0] MUL_LOAD = 4'(MUL_LAT - 2);

    hazard_state_t    state_q, state_d;
    logic [3:0]       mul_cnt_q, mul_cnt_d;
    logic             mul_busy_q;
    logic [CNT_W-1:0] stall_cnt_q;
    hz_ctl_t          ctl;
    logic             load_use;
    logic             ex_mul;
    logic             br_taken;

    load_use_det u_load_use_det (
        .ex_valid    (hz.ex_valid),
        .ex_mem_read (hz.ex_mem_read),
        .ex_rd       (hz.ex_rd),
        .id_valid    (hz.id_valid),
        .id_rs1      (hz.id_rs1),
        .id_rs2      (hz.id_rs2),
        .id_uses_rs2 (hz.id_uses_rs2),
        .hazard      (load_use)
    );

    assign ex_mul   = hz.ex_valid && is_mul(hz.ex_alu_op);
    assign br_taken = hz.ex_valid && hz.ex_branch && hz.ex_zero;

    always_comb begin
        state_d   = state_q;
        mul_cnt_d = mul_cnt_q;
        ctl       = CTL_RUN;
        if (hz.mem_wait) begin
            // Freeze: no enables, no flushes; redirect is re-evaluated once the wait drops.
            ctl = '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (ex_mul) begin
                        ctl       = CTL_HOLD;
                        mul_cnt_d = MUL_LOAD;
                        state_d   = MUL_WAIT;
                    end else if (br_taken) begin
                        ctl.branch_taken = 1'b1;
                        ctl.ifid_flush   = 1'b1;
                        ctl.idex_flush   = 1'b1;
                    end else if (load_use) begin
                        ctl.pc_en      = 1'b0;
                        ctl.ifid_en    = 1'b0;
                        ctl.idex_flush = 1'b1;
                    end
                end
                MUL_WAIT: begin
                    // Release cycle leaves the defaults: the MUL retires from EX on this edge.
                    if (mul_cnt_q != '0) begin
                        ctl       = CTL_HOLD;
                        mul_cnt_d = mul_cnt_q - 4'd1;
                    end else begin
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            mul_cnt_q   <= '0;
            mul_busy_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            mul_cnt_q  <= mul_cnt_d;
            mul_busy_q <= (state_d == MUL_WAIT);
            if (!ctl.pc_en && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign hz.pc_en        = ctl.pc_en;
    assign hz.ifid_en      = ctl.ifid_en;
    assign hz.idex_en      = ctl.idex_en;
    assign hz.ifid_flush   = ctl.ifid_flush;
    assign hz.idex_flush   = ctl.idex_flush;
    assign hz.exmem_bubble = ctl.exmem_bubble;
    assign hz.branch_taken = ctl.branch_taken;
    assign hz.mul_busy     = mul_busy_q;
    assign hz.stall_cnt    = stall_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vector table, multi-cycle sequences, random vs model.
module tb_hazard_ctrl;
    import cpu_pkg::*;

    localparam int MUL_LAT = 4;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic       mem_wait;
        logic       id_valid;
        logic [4:0] id_rs1;
        logic [4:0] id_rs2;
        logic       id_uses_rs2;
        logic       ex_valid;
        logic [4:0] ex_rd;
        logic       ex_mem_read;
        logic [2:0] ex_alu_op;
        logic       ex_branch;
        logic       ex_zero;
    } stim_t;

    // {pc_en, ifid_en, idex_en, ifid_flush, idex_flush, exmem_bubble, branch_taken}
    typedef logic [6:0] outs_t;

    typedef struct {
        stim_t s;
        outs_t e;
    } vec_t;

    localparam outs_t O_RUN  = 7'b1110000;
    localparam outs_t O_LU   = 7'b0010100;
    localparam outs_t O_BR   = 7'b1111101;
    localparam outs_t O_HOLD = 7'b0000010;
    localparam outs_t O_FRZ  = 7'b0000000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

    hazard_ctrl #(.MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz.slave)
    );

    always #5 clk = ~clk;

    int    n_cmp = 0;
    int    n_bad = 0;
    int    occ   = 0;   // cycles the current MUL has already spent in EX (0 = none)
    int    m_cnt = 0;
    stim_t cur;
    vec_t  vecs[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic stim_t mk(input logic mw, input logic idv, input int rs1, input int rs2,
                                 input logic u2, input logic exv, input int rd, input logic mr,
                                 input logic [2:0] op, input logic br, input logic z);
        stim_t s;
        s.mem_wait    = mw;
        s.id_valid    = idv;
        s.id_rs1      = 5'(rs1);
        s.id_rs2      = 5'(rs2);
        s.id_uses_rs2 = u2;
        s.ex_valid    = exv;
        s.ex_rd       = 5'(rd);
        s.ex_mem_read = mr;
        s.ex_alu_op   = op;
        s.ex_branch   = br;
        s.ex_zero     = z;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        cur            = s;
        hz.mem_wait    = s.mem_wait;
        hz.id_valid    = s.id_valid;
        hz.id_rs1      = s.id_rs1;
        hz.id_rs2      = s.id_rs2;
        hz.id_uses_rs2 = s.id_uses_rs2;
        hz.ex_valid    = s.ex_valid;
        hz.ex_rd       = s.ex_rd;
        hz.ex_mem_read = s.ex_mem_read;
        hz.ex_alu_op   = s.ex_alu_op;
        hz.ex_branch   = s.ex_branch;
        hz.ex_zero     = s.ex_zero;
    endtask

    // Reference rules: freeze beats everything, a MUL holds the pipe until it has spent
    // MUL_LAT cycles in EX, then branch, then load-use.
    function automatic outs_t model_out(input stim_t s, input int o);
        logic lu;
        lu = s.ex_valid && s.ex_mem_read && (s.ex_rd != 0) && s.id_valid &&
             ((s.ex_rd == s.id_rs1) || (s.id_uses_rs2 && (s.ex_rd == s.id_rs2)));
        if (s.mem_wait)                                    return O_FRZ;
        if (o == MUL_LAT - 1)                              return O_RUN;
        if (o > 0)                                         return O_HOLD;
        if (s.ex_valid && s.ex_alu_op == 3'b111)           return O_HOLD;
        if (s.ex_valid && s.ex_branch && s.ex_zero)        return O_BR;
        if (lu)                                            return O_LU;
        return O_RUN;
    endfunction

    function automatic int model_next_occ(input stim_t s, input int o);
        if (s.mem_wait)           return o;
        if (o == MUL_LAT - 1)     return 0;
        if (o > 0)                return o + 1;
        return (s.ex_valid && s.ex_alu_op == 3'b111) ? 1 : 0;
    endfunction

    function automatic outs_t dut_outs();
        return {hz.pc_en, hz.ifid_en, hz.idex_en, hz.ifid_flush,
                hz.idex_flush, hz.exmem_bubble, hz.branch_taken};
    endfunction

    // Called just after a rising edge with inputs applied; returns just after the next one.
    task automatic run_cycle(input string tag);
        outs_t exp;
        @(negedge clk);
        exp = model_out(cur, occ);
        check({tag, " outs"}, 32'(dut_outs()), 32'(exp));
        check({tag, " mul_busy"}, 32'(hz.mul_busy), 32'(occ > 0));
        check({tag, " stall_cnt"}, 32'(hz.stall_cnt), 32'(m_cnt));
        if (!exp[6] && m_cnt < CNT_MAX) m_cnt++;
        occ = model_next_occ(cur, occ);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0));
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        occ   = 0;
        m_cnt = 0;
        @(posedge clk);
        #1;
    endtask

    stim_t idle, mul, mul_mw, lu_s, mw_s;

    initial begin
        idle   = mk(0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0);
        mul    = mk(0, 1, 3, 4, 1, 1, 9, 0, 3'b111, 0, 0);
        mul_mw = mk(1, 1, 3, 4, 1, 1, 9, 0, 3'b111, 0, 0);
        lu_s   = mk(0, 1, 5, 0, 0, 1, 5, 1, 3'b000, 0, 0);
        mw_s   = mk(1, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0);

        vecs.push_back('{idle, O_RUN});
        vecs.push_back('{lu_s, O_LU});
        vecs.push_back('{mk(0, 1, 0, 0, 0, 1, 0, 1, 3'b000, 0, 0), O_RUN});
        vecs.push_back('{mk(0, 1, 2, 7, 1, 1, 7, 1, 3'b000, 0, 0), O_LU});
        vecs.push_back('{mk(0, 1, 2, 7, 0, 1, 7, 1, 3'b000, 0, 0), O_RUN});
        vecs.push_back('{mk(0, 0, 5, 0, 0, 1, 5, 1, 3'b000, 0, 0), O_RUN});
        vecs.push_back('{mk(0, 1, 5, 0, 0, 0, 5, 1, 3'b000, 0, 0), O_RUN});
        vecs.push_back('{mk(0, 1, 5, 6, 1, 1, 0, 0, 3'b001, 1, 1), O_BR});
        vecs.push_back('{mk(0, 1, 5, 6, 1, 1, 0, 0, 3'b001, 1, 0), O_RUN});
        vecs.push_back('{mk(0, 1, 5, 6, 1, 0, 0, 0, 3'b001, 1, 1), O_RUN});
        vecs.push_back('{mk(1, 1, 5, 0, 0, 1, 5, 1, 3'b000, 0, 0), O_FRZ});
        vecs.push_back('{mk(1, 1, 5, 6, 1, 1, 0, 0, 3'b001, 1, 1), O_FRZ});

        // Reset state with idle inputs, observed while reset is held.
        apply(idle);
        #2;
        check("reset outs", 32'(dut_outs()), 32'(O_RUN));
        check("reset mul_busy", 32'(hz.mul_busy), 32'd0);
        check("reset stall_cnt", 32'(hz.stall_cnt), 32'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            apply(vecs[i].s);
            #1;
            check($sformatf("vec%0d table", i), 32'(dut_outs()), 32'(vecs[i].e));
            run_cycle($sformatf("vec%0d", i));
        end
        apply(idle);
        run_cycle("after table");

        // Single MUL: three hold cycles, release on the fourth.
        do_reset();
        apply(mul);
        repeat (MUL_LAT) run_cycle("mul");
        apply(idle);
        check("mul stall_cnt", 32'(hz.stall_cnt), 32'(MUL_LAT - 1));
        check("mul busy after", 32'(hz.mul_busy), 32'd0);
        run_cycle("mul idle");

        // MUL with a two-cycle memory wait in the middle of the hold.
        do_reset();
        apply(mul);
        repeat (2) run_cycle("mulmw a");
        apply(mul_mw);
        repeat (2) run_cycle("mulmw wait");
        apply(mul);
        repeat (2) run_cycle("mulmw b");
        apply(idle);
        check("mulmw stall_cnt", 32'(hz.stall_cnt), 32'd5);
        check("mulmw busy after", 32'(hz.mul_busy), 32'd0);
        run_cycle("mulmw idle");

        // Back-to-back MULs: the second starts its own occupancy right after release.
        do_reset();
        apply(mul);
        repeat (2 * MUL_LAT) run_cycle("b2b");
        apply(idle);
        check("b2b stall_cnt", 32'(hz.stall_cnt), 32'(2 * (MUL_LAT - 1)));
        run_cycle("b2b idle");

        // Asynchronous reset in the middle of MUL_WAIT.
        do_reset();
        apply(mul);
        repeat (2) run_cycle("rstmul");
        check("rstmul busy before", 32'(hz.mul_busy), 32'd1);
        apply(idle);
        rst_n = 1'b0;
        #1;
        check("rstmul busy", 32'(hz.mul_busy), 32'd0);
        check("rstmul outs", 32'(dut_outs()), 32'(O_RUN));
        check("rstmul stall_cnt", 32'(hz.stall_cnt), 32'd0);
        occ   = 0;
        m_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_cycle("rstmul idle");

        // Randomised traffic against the reference rules.
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            stim_t s;
            s.mem_wait    = ($urandom_range(0, 7) == 0);
            s.id_valid    = 1'($urandom_range(0, 1));
            s.id_rs1      = 5'($urandom_range(0, 3));
            s.id_rs2      = 5'($urandom_range(0, 3));
            s.id_uses_rs2 = 1'($urandom_range(0, 1));
            s.ex_valid    = ($urandom_range(0, 3) != 0);
            s.ex_rd       = 5'($urandom_range(0, 3));
            s.ex_mem_read = 1'($urandom_range(0, 1));
            s.ex_alu_op   = ($urandom_range(0, 9) == 0) ? 3'b111 : 3'($urandom_range(0, 6));
            s.ex_branch   = ($urandom_range(0, 3) == 0);
            s.ex_zero     = 1'($urandom_range(0, 1));
            apply(s);
            run_cycle("rand");
        end

        // Saturation of the stall counter.
        do_reset();
        apply(mw_s);
        repeat (CNT_MAX + 5) run_cycle("sat");
        check("sat full", 32'(hz.stall_cnt), 32'(CNT_MAX));
        apply(lu_s);
        run_cycle("sat lu");
        check("sat hold", 32'(hz.stall_cnt), 32'(CNT_MAX));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 64-bit five-stage core. Sits beside the ID/EX pipeline registers and drives the pipeline enables, flushes and branch redirect from the decoded control signals. Handles load-use stalls, taken-BEQ flushes, multi-cycle MUL occupancy of EX, and global memory-wait freezes. Also keeps a saturating stall-cycle counter for performance analysis.

## Interface
Parameters:
- MUL_LAT, 4, EX occupancy of a MUL in cycles; legal range 2..16
- CNT_W, 32, width of stall_cnt

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- mem_wait  in  1  data/instruction memory not ready; freeze the whole pipeline
- id_valid  in  1  valid instruction in ID
- id_rs1  in  5  ID source register 1
- id_rs2  in  5  ID source register 2
- id_uses_rs2  in  1  ID instruction reads rs2 (R-type, SW, BEQ)
- ex_valid  in  1  valid instruction in EX
- ex_rd  in  5  EX destination register
- ex_mem_read  in  1  EX instruction is LW
- ex_alu_op  in  3  EX ALU op code; 3'b111 = MUL
- ex_branch  in  1  EX instruction is BEQ
- ex_zero  in  1  ALU zero flag for the EX instruction
- pc_en  out  1  PC update enable
- ifid_en  out  1  IF/ID register enable
- idex_en  out  1  ID/EX register enable
- ifid_flush  out  1  load a NOP into IF/ID
- idex_flush  out  1  load a bubble into ID/EX
- exmem_bubble  out  1  write a bubble into EX/MEM, not the EX result
- branch_taken  out  1  select the branch target for the PC
- mul_busy  out  1  FSM in MUL_WAIT
- stall_cnt  out  CNT_W  cycles with pc_en=0, saturating

## Operation
- FSM states: RUN, MUL_WAIT. The 4-bit down-counter mul_cnt is used only in MUL_WAIT.
- Priority, highest first: mem_wait > MUL occupancy > branch taken > load-use.
- mem_wait=1: all enables 0, all flushes, bubble and branch_taken 0. State, mul_cnt and any pending redirect are frozen. The redirect is re-evaluated when mem_wait drops.
- RUN, ex_valid && ex_alu_op==111: hold PC, IF/ID and ID/EX (enables 0), exmem_bubble=1, load mul_cnt=MUL_LAT-2, go to MUL_WAIT.
- MUL_WAIT, mul_cnt!=0: same hold outputs, mul_cnt decrements.
- MUL_WAIT, mul_cnt==0: release. All enables 1, exmem_bubble=0, return to RUN. The MUL leaves EX on this edge.
- Branch taken (RUN, ex_valid && ex_branch && ex_zero): branch_taken=1, ifid_flush=1, idex_flush=1, all enables 1.
- Load-use (RUN, ex_valid && ex_mem_read && ex_rd!=0 && id_valid && (ex_rd==id_rs1 || (id_uses_rs2 && ex_rd==id_rs2))): pc_en=0, ifid_en=0, idex_en=1, idex_flush=1. Lasts one cycle.
- ex_rd==0 never causes a stall.
- Load-use checks are ignored in MUL_WAIT.
- Default: all enables 1, all flushes 0.
- stall_cnt increments on every cycle with pc_en=0 and holds at all-ones.

## Timing
- All outputs except mul_busy and stall_cnt are combinational from the current state and inputs, valid in the same cycle.
- mul_busy and stall_cnt are registered.
- Reset values: state RUN, mul_cnt 0, mul_busy 0, stall_cnt 0. With idle inputs: pc_en=ifid_en=idex_en=1, all other outputs 0.
- MUL holds the pipeline for exactly MUL_LAT-1 cycles; EX occupancy is MUL_LAT cycles.
- Back-to-back MULs: the second MUL enters EX on the release edge and starts a new occupancy in the next cycle (RUN).
- A load-use stall adds one cycle. A taken branch costs two flushed slots.
- Reset mid-MUL: the FSM returns to RUN asynchronously and stall_cnt clears.
- mem_wait during MUL_WAIT extends the hold by exactly the number of wait cycles.

## Structure
- Shared package cpu_pkg holds the ALU op localparams (ADD 000 … MUL 111), the hazard_state_t enum {RUN, MUL_WAIT}, and REG_AW=5.
- One combinational sub-module, load_use_det, implements the register-compare term. The FSM, counter and output mux stay in hazard_ctrl.

## Test plan
- Reset with idle inputs: pc_en=ifid_en=idex_en=1, every other output 0, stall_cnt=0.
- LW, ex_rd=5 in EX; ID id_rs1=5 -> one cycle with pc_en=0, ifid_en=0, idex_flush=1, stall_cnt becomes 1. Same stimulus with ex_rd=0 -> no stall.
- MUL in EX, MUL_LAT=4 -> 3 hold cycles with exmem_bubble=1 and mul_busy=1 from the second cycle. Release on the 4th cycle; stall_cnt=3.
- MUL in EX with mem_wait=1 for 2 cycles in the middle -> 5 total hold cycles; mul_cnt is frozen during the wait.
- BEQ with ex_zero=1 -> branch_taken=1, ifid_flush=1, idex_flush=1 for one cycle. With ex_zero=0 -> no flush.
- rst_n asserted during MUL_WAIT -> mul_busy=0 and enables=1 immediately; stall_cnt=0. A forced stall_cnt=all-ones plus a stall keeps all-ones.
